// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing masters A/B onto an async single-port memory.
// Read done 2 cycles, write done 4 cycles after grant; gnt held low while busy.
module mem_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic [DW-1:0] mem_din,
  output logic          mem_ewr,
  output logic [AW-1:0] mem_dir,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_b;
  logic          r_owner_b;
  logic          r_we;
  logic          r_ewr;
  logic [AW-1:0] r_dir;
  logic [DW-1:0] r_din;
  logic          r_a_done;
  logic          r_b_done;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          w_xfer;
  logic          w_finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // On a tie the master not served last wins; a lone requester always wins.
  always_comb begin
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (a_req && (!b_req || r_last_b)) w_a_gnt = 1'b1;
        else if (b_req)                    w_b_gnt = 1'b1;
        if (w_a_gnt || w_b_gnt) w_state_nxt = SETUP;
      end
      SETUP:   w_state_nxt = r_we ? STROBE : IDLE;
      STROBE:  w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_xfer   = w_a_gnt || w_b_gnt;
  assign w_finish = ((r_state == SETUP) && !r_we) || (r_state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
      r_we      <= 1'b0;
      r_ewr     <= 1'b0;
      r_dir     <= '0;
      r_din     <= '0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_ewr    <= (w_state_nxt == STROBE);
      r_a_done <= w_finish && !r_owner_b;
      r_b_done <= w_finish && r_owner_b;
      if (w_xfer) begin
        r_owner_b <= w_b_gnt;
        r_last_b  <= w_b_gnt;
        r_we      <= w_b_gnt ? b_we    : a_we;
        r_dir     <= w_b_gnt ? b_addr  : a_addr;
        r_din     <= w_b_gnt ? b_wdata : a_wdata;
      end
      // Memory output is combinational; capture it at the end of SETUP only.
      if ((r_state == SETUP) && !r_we) begin
        if (r_owner_b) r_b_rdata <= mem_dout;
        else           r_a_rdata <= mem_dout;
      end
    end
  end

  assign a_gnt   = w_a_gnt && rst_n;
  assign b_gnt   = w_b_gnt && rst_n;
  assign a_done  = r_a_done;
  assign b_done  = r_b_done;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign mem_din = r_din;
  assign mem_dir = r_dir;
  assign mem_ewr = r_ewr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, a_gnt, a_done;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_done;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_ewr;
  logic [AW-1:0] mem_dir;

  logic [DW-1:0] mem     [0:31];
  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] exp_rdata [0:1];
  logic [DW-1:0] dout_xor;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_din(mem_din), .mem_ewr(mem_ewr), .mem_dir(mem_dir), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_ewr === 1'b1) mem[mem_dir] <= mem_din;
  assign mem_dout = mem[mem_dir] ^ dout_xor;

  task automatic set_req(input int m, input bit req, input bit we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd);
    if (m == 0) begin a_req = req; a_we = we; a_addr = ad; a_wdata = wd; end
    else        begin b_req = req; b_we = we; b_addr = ad; b_wdata = wd; end
  endtask

  // Called just after a negedge; returns at the negedge of cycle 1 (SETUP) with t0 = transfer cycle.
  task automatic issue(input int m, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                       output int t0);
    bit got;
    got = 0;
    t0 = -1;
    set_req(m, 1'b1, we, ad, wd);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (((m == 0) ? a_gnt : b_gnt) === 1'b1) begin got = 1; t0 = cyc; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout master=%0d: no grant seen, required one within 20 cycles", m);
    end
    set_req(m, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b1, 5'd7, 32'h1234);
    set_req(1, 1'b1, 1'b0, 5'd9, 32'h5678);
    repeat (3) @(negedge clk);
    checks++; if (mem_ewr !== 1'b0) begin errors++; $display("FAIL reset_ewr got=%b want=0", mem_ewr); end
    checks++; if (mem_dir !== '0) begin errors++; $display("FAIL reset_dir got=%0d want=0", mem_dir); end
    checks++; if (mem_din !== '0) begin errors++; $display("FAIL reset_din got=%0d want=0", mem_din); end
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got a=%b b=%b want 0 0", a_gnt, b_gnt); end
    checks++; if (a_done !== 1'b0 || b_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got a=%b b=%b want 0 0", a_done, b_done); end
    checks++; if (a_rdata !== '0 || b_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got a=%0d b=%0d want 0 0", a_rdata, b_rdata); end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int t0;
    issue(0, 1'b1, 5'd1, 32'd1050, t0);
    ref_mem[1] = 32'd1050;
    for (int r = 1; r <= 4; r++) begin
      checks++;
      if (mem_ewr !== 1'(r == 2)) begin errors++; $display("FAIL wr_ewr rel=%0d got=%b want=%b", r, mem_ewr, r == 2); end
      if (r <= 3) begin
        checks++;
        if (mem_dir !== 5'd1 || mem_din !== 32'd1050) begin
          errors++; $display("FAIL wr_addr_data rel=%0d got dir=%0d din=%0d want 1 1050", r, mem_dir, mem_din); end
      end
      checks++;
      if (a_done !== 1'(r == 4)) begin errors++; $display("FAIL wr_done rel=%0d got=%b want=%b", r, a_done, r == 4); end
      if (r < 4) @(negedge clk);
    end
    issue(1, 1'b0, 5'd1, '0, t0);
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL rd_done_early got=%b want=0", b_done); end
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL rd_done got=%b want=1", b_done); end
    checks++; if (b_rdata !== 32'd1050) begin errors++; $display("FAIL rd_data got=%0d want=1050", b_rdata); end
    checks++; if (a_rdata !== exp_rdata[0]) begin
      errors++; $display("FAIL rd_other_rdata got=%0d want=%0d", a_rdata, exp_rdata[0]); end
    exp_rdata[1] = 32'd1050;
  endtask

  task automatic test_alternation;
    int t0, ngr, lg, nd;
    issue(0, 1'b1, 5'd15, 32'd2100, t0); ref_mem[15] = 32'd2100; run_to(t0 + 4);
    issue(1, 1'b1, 5'd31, 32'd3150, t0); ref_mem[31] = 32'd3150; run_to(t0 + 4);
    set_req(0, 1'b1, 1'b0, 5'd15, '0);
    set_req(1, 1'b1, 1'b0, 5'd31, '0);
    ngr = 0; lg = 0; nd = 0;
    for (int i = 0; i < 30 && ngr < 4; i++) begin
      if (i > 0 && (a_done === 1'b1 || b_done === 1'b1)) begin
        nd++;
        checks++;
        if ((a_done === 1'b1 && a_rdata !== 32'd2100) || (b_done === 1'b1 && b_rdata !== 32'd3150)) begin
          errors++; $display("FAIL alt_rdata got a=%0d b=%0d want 2100 3150", a_rdata, b_rdata); end
      end
      #1;
      if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
        checks++;
        if ({a_gnt, b_gnt} !== ((ngr % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_order grant#%0d got a=%b b=%b want %s", ngr, a_gnt, b_gnt, (ngr % 2 == 0) ? "A" : "B"); end
        if (ngr > 0) begin
          checks++;
          if (cyc - lg != 2) begin errors++; $display("FAIL alt_spacing got=%0d want=2", cyc - lg); end
        end
        lg = cyc;
        ngr++;
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    checks++; if (ngr != 4) begin errors++; $display("FAIL alt_grants got=%0d want=4", ngr); end
    run_to(lg + 2);
    checks++; if (b_done !== 1'b1 || b_rdata !== 32'd3150) begin
      errors++; $display("FAIL alt_last got done=%b data=%0d want 1 3150", b_done, b_rdata); end
    checks++; if (nd != 3) begin errors++; $display("FAIL alt_done_count got=%0d want=3", nd); end
    exp_rdata[0] = 32'd2100;
    exp_rdata[1] = 32'd3150;
  endtask

  task automatic test_b_only;
    int nd;
    nd = 0;
    set_req(1, 1'b1, 1'b0, 5'd31, '0);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL bonly_agnt i=%0d got=%b want=0", i, a_gnt); end
      checks++; if (b_gnt !== 1'(i % 2 == 0)) begin
        errors++; $display("FAIL bonly_bgnt i=%0d got=%b want=%b", i, b_gnt, i % 2 == 0); end
      @(negedge clk);
      if (b_done === 1'b1) nd++;
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    checks++; if (nd != 4) begin errors++; $display("FAIL bonly_done_count got=%0d want=4", nd); end
    checks++; if (b_rdata !== 32'd3150) begin errors++; $display("FAIL bonly_rdata got=%0d want=3150", b_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_strobe;
    int t0;
    issue(0, 1'b1, 5'd31, 32'd3150, t0);
    @(negedge clk);
    checks++; if (mem_ewr !== 1'b1) begin errors++; $display("FAIL rst_pre_strobe got=%b want=1", mem_ewr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_ewr !== 1'b0 || mem_dir !== '0 || mem_din !== '0) begin
      errors++; $display("FAIL rst_async got ewr=%b dir=%0d din=%0d want 0 0 0", mem_ewr, mem_dir, mem_din); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_no_done i=%0d got=%b want=0", i, a_done); end
    end
    rst_n = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    checks++; if (a_rdata !== '0 || b_rdata !== '0) begin
      errors++; $display("FAIL rst_rdata got a=%0d b=%0d want 0 0", a_rdata, b_rdata); end
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    set_req(1, 1'b1, 1'b0, 5'd1, '0);
    #1;
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_tie got a=%b b=%b want 1 0", a_gnt, b_gnt); end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_rdata !== 32'd1050) begin
      errors++; $display("FAIL rst_after_read got done=%b data=%0d want 1 1050", a_done, a_rdata); end
    exp_rdata[0] = 32'd1050;
  endtask

  task automatic test_dout_change;
    int t0;
    issue(0, 1'b0, 5'd15, '0, t0);
    @(posedge clk);
    #1 dout_xor = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_rdata !== 32'd2100) begin
      errors++; $display("FAIL dout_sample got done=%b data=%0d want 1 2100", a_done, a_rdata); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0 || a_rdata !== 32'd2100) begin
      errors++; $display("FAIL dout_hold got done=%b data=%0d want 0 2100", a_done, a_rdata); end
    dout_xor = '0;
    exp_rdata[0] = 32'd2100;
  endtask

  // Transaction model: one access in flight; grants follow the round-robin rule; memory updated at grant.
  task automatic test_random;
    bit pend [0:1];
    bit rwe [0:1];
    logic [AW-1:0] rad [0:1];
    logic [DW-1:0] rwd [0:1];
    bit active, twe, last_b;
    int own, dur, ts, w, r;
    logic [AW-1:0] tad;
    logic [DW-1:0] twd, trd;
    active = 0; last_b = 0; own = 0; dur = 0; ts = 0; twe = 0; tad = '0; twd = '0; trd = '0;
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 400; n++) begin
      if (active) begin
        r = cyc - ts;
        checks++; if (mem_ewr !== 1'(twe && r == 2)) begin
          errors++; $display("FAIL rnd_ewr cyc=%0d rel=%0d got=%b want=%b", cyc, r, mem_ewr, twe && r == 2); end
        if (r < dur) begin
          checks++; if (mem_dir !== tad || mem_din !== twd) begin
            errors++; $display("FAIL rnd_bus cyc=%0d got dir=%0d din=%h want %0d %h", cyc, mem_dir, mem_din, tad, twd); end
        end
        checks++; if (a_done !== 1'(r == dur && own == 0) || b_done !== 1'(r == dur && own == 1)) begin
          errors++; $display("FAIL rnd_done cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, a_done, b_done,
                             r == dur && own == 0, r == dur && own == 1); end
        if (r == dur) begin
          if (!twe) exp_rdata[own] = trd;
          checks++; if (a_rdata !== exp_rdata[0] || b_rdata !== exp_rdata[1]) begin
            errors++; $display("FAIL rnd_rdata cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, a_rdata, b_rdata,
                               exp_rdata[0], exp_rdata[1]); end
          active = 0;
        end
      end else begin
        checks++; if (mem_ewr !== 1'b0 || a_done !== 1'b0 || b_done !== 1'b0) begin
          errors++; $display("FAIL rnd_idle cyc=%0d got ewr=%b a_done=%b b_done=%b want 0 0 0", cyc, mem_ewr, a_done, b_done); end
      end
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && n < 380 && $urandom_range(0, 2) != 0) begin
          pend[m] = 1;
          rwe[m] = 1'($urandom_range(0, 1));
          rad[m] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(28, 31));
          rwd[m] = $urandom;
        end
      end
      set_req(0, pend[0], rwe[0], rad[0], rwd[0]);
      set_req(1, pend[1], rwe[1], rad[1], rwd[1]);
      #1;
      w = -1;
      if (!active) begin
        if (pend[0] && pend[1]) w = last_b ? 0 : 1;
        else if (pend[0])       w = 0;
        else if (pend[1])       w = 1;
      end
      checks++; if (a_gnt !== 1'(w == 0) || b_gnt !== 1'(w == 1)) begin
        errors++; $display("FAIL rnd_gnt cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, a_gnt, b_gnt, w == 0, w == 1); end
      if (w >= 0) begin
        active = 1; own = w; ts = cyc; twe = rwe[w]; tad = rad[w]; twd = rwd[w];
        dur = twe ? 4 : 2;
        if (twe) ref_mem[tad] = twd;
        trd = ref_mem[tad];
        pend[w] = 0;
        last_b = (w == 1);
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    dout_xor = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    test_reset;
    test_write_read;
    test_alternation;
    test_b_only;
    test_reset_strobe;
    test_dout_change;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
